// File: rtl/alu_operand_loader.sv
// Operand-entry stage ahead of the ALU. Two raw push-buttons are synchronized
// and debounced into single-cycle press events; those events step a small FSM
// that captures operand A, operand B and the opcode from a shared switch bank.
//
// Button conditioner: 2-flop synchronizer, stability counter, and a
// single-cycle press pulse on each accepted 0->1 level change.
module alu_operand_loader_btn #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic          level;
    logic [CW-1:0] cnt;

    // Synchronize, then accept a new level only after DEBOUNCE_CYCLES
    // consecutive cycles of disagreement; press fires with a rising accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync_2;
                    cnt   <= '0;
                    press <= sync_2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// state   | meaning
// WAIT_A  | next load captures operand A
// WAIT_B  | next load captures operand B
// WAIT_OP | next load captures the opcode
// READY   | operands and opcode held for the ALU; next load starts over at A
module alu_operand_loader #(
    parameter int DATA_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] sw_data,
    input  logic [2:0]            sw_opcode,
    input  logic                  btn_load,
    input  logic                  btn_clear,
    output logic [DATA_WIDTH-1:0] portA,
    output logic [DATA_WIDTH-1:0] portB,
    output logic [2:0]            opcode,
    output logic                  operands_valid,
    output logic                  exec_pulse,
    output logic [1:0]            load_state
);
    typedef enum logic [1:0] {
        WAIT_A  = 2'b00,
        WAIT_B  = 2'b01,
        WAIT_OP = 2'b10,
        READY   = 2'b11
    } state_t;

    state_t state_q;
    state_t state_next;
    logic   load_evt;
    logic   clear_evt;
    logic   cap_a;
    logic   cap_b;
    logic   cap_op;
    logic   clr;

    alu_operand_loader_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_load (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_load),
        .press (load_evt)
    );

    alu_operand_loader_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_clear),
        .press (clear_evt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_A;
        end else begin
            state_q <= state_next;
        end
    end

    // Next state and capture strobes; clear overrides a simultaneous load.
    always_comb begin
        state_next = state_q;
        cap_a      = 1'b0;
        cap_b      = 1'b0;
        cap_op     = 1'b0;
        clr        = 1'b0;
        if (clear_evt) begin
            clr        = 1'b1;
            state_next = WAIT_A;
        end else if (load_evt) begin
            case (state_q)
                WAIT_A: begin
                    cap_a      = 1'b1;
                    state_next = WAIT_B;
                end
                WAIT_B: begin
                    cap_b      = 1'b1;
                    state_next = WAIT_OP;
                end
                WAIT_OP: begin
                    cap_op     = 1'b1;
                    state_next = READY;
                end
                default: begin
                    cap_a      = 1'b1;
                    state_next = WAIT_B;
                end
            endcase
        end
    end

    // Held operand registers and the one-cycle pulse on entry into READY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            portA      <= '0;
            portB      <= '0;
            opcode     <= '0;
            exec_pulse <= 1'b0;
        end else begin
            exec_pulse <= (state_next == READY) && (state_q != READY);
            if (clr) begin
                portA  <= '0;
                portB  <= '0;
                opcode <= '0;
            end else begin
                if (cap_a)  portA  <= sw_data;
                if (cap_b)  portB  <= sw_data;
                if (cap_op) opcode <= sw_opcode;
            end
        end
    end

    assign operands_valid = (state_q == READY);
    assign load_state     = state_q;
endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: directed scenarios followed by random button
// activity, compared against an operation-level model of the entry sequence.
module tb_alu_operand_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sw_data = '0;
    logic [2:0] sw_opcode = '0;
    logic       btn_load = 1'b0;
    logic       btn_clear = 1'b0;
    logic [7:0] portA;
    logic [7:0] portB;
    logic [2:0] opcode;
    logic       operands_valid;
    logic       exec_pulse;
    logic [1:0] load_state;

    int vectors = 0;
    int miscompares = 0;
    int exec_seen = 0;

    // model: how many items of the current operation have been entered
    int         m_step = 0;
    logic [7:0] m_a = '0;
    logic [7:0] m_b = '0;
    logic [2:0] m_op = '0;
    int         m_exec = 0;

    alu_operand_loader #(.DATA_WIDTH(8), .DEBOUNCE_CYCLES(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sw_data        (sw_data),
        .sw_opcode      (sw_opcode),
        .btn_load       (btn_load),
        .btn_clear      (btn_clear),
        .portA          (portA),
        .portB          (portB),
        .opcode         (opcode),
        .operands_valid (operands_valid),
        .exec_pulse     (exec_pulse),
        .load_state     (load_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (exec_pulse) exec_seen++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_load(input logic [7:0] d, input logic [2:0] op);
        if (m_step == 0 || m_step == 3) begin
            m_a = d;
            m_step = 1;
        end else if (m_step == 1) begin
            m_b = d;
            m_step = 2;
        end else begin
            m_op = op;
            m_step = 3;
            m_exec++;
        end
    endfunction

    function automatic void model_clear();
        m_a = '0;
        m_b = '0;
        m_op = '0;
        m_step = 0;
    endfunction

    task automatic check_all(input string tag);
        check({tag, " state"}, 32'(load_state), 32'(m_step));
        check({tag, " portA"}, 32'(portA), 32'(m_a));
        check({tag, " portB"}, 32'(portB), 32'(m_b));
        check({tag, " opcode"}, 32'(opcode), 32'(m_op));
        check({tag, " valid"}, 32'(operands_valid), 32'(m_step == 3));
        check({tag, " exec_pulse"}, 32'(exec_pulse), 32'(0));
        check({tag, " exec_count"}, 32'(exec_seen), 32'(m_exec));
    endtask

    // Drive the buttons for `hold` cycles, then leave them released long enough
    // for the debouncer to settle; lat = cycles until any held output changed.
    task automatic press(input bit ld, input bit cl, input int hold,
                         input logic [7:0] d, input logic [2:0] op, output int lat);
        logic [21:0] snap;
        lat = -1;
        @(negedge clk);
        snap = {load_state, portA, portB, opcode, operands_valid};
        sw_data = d;
        sw_opcode = op;
        btn_load = ld;
        btn_clear = cl;
        for (int i = 1; i <= hold + 25; i++) begin
            @(negedge clk);
            if (lat < 0 && {load_state, portA, portB, opcode, operands_valid} !== snap) lat = i;
            if (i == hold) begin
                btn_load = 1'b0;
                btn_clear = 1'b0;
            end
        end
    endtask

    task automatic do_load(input string tag, input logic [7:0] d, input logic [2:0] op, input int hold);
        int lat;
        press(1'b1, 1'b0, hold, d, op, lat);
        if (hold >= 20) begin
            model_load(d, op);
            check({tag, " latency"}, 32'(lat >= 18 && lat <= 20), 32'(1));
        end
        check_all(tag);
    endtask

    task automatic do_clear(input string tag, input bit with_load, input int hold);
        int lat;
        press(with_load, 1'b1, hold, $urandom_range(0, 255), $urandom_range(0, 7), lat);
        if (hold >= 20) model_clear();
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check({tag, " async state"}, 32'(load_state), 32'(0));
        check({tag, " async portA"}, 32'(portA), 32'(0));
        check({tag, " async portB"}, 32'(portB), 32'(0));
        check({tag, " async opcode"}, 32'(opcode), 32'(0));
        check({tag, " async valid"}, 32'(operands_valid), 32'(0));
        check({tag, " async exec"}, 32'(exec_pulse), 32'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        #1;
        check_all("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // full entry sequence
        do_load("load_a", 8'h3C, 3'd0, 30);
        do_load("load_b", 8'h05, 3'd0, 30);
        do_load("load_op", 8'h00, 3'd2, 30);
        // restart from READY keeps B/opcode
        do_load("restart", 8'hFF, 3'd6, 30);

        // hold-length behaviour
        do_load("hold10", 8'hAA, 3'd1, 10);
        do_load("hold20", 8'h77, 3'd1, 20);
        do_load("hold200", 8'h12, 3'd5, 200);

        // simultaneous load and clear in WAIT_B
        do_load("to_wait_b", 8'h11, 3'd3, 25);
        do_clear("both_wait_b", 1'b1, 30);

        // clear from WAIT_OP
        do_load("a2", 8'h21, 3'd0, 25);
        do_load("b2", 8'h42, 3'd0, 25);
        do_clear("clear_wait_op", 1'b0, 30);

        // async reset from WAIT_OP with loaded registers
        do_load("a3", 8'h9A, 3'd0, 25);
        do_load("b3", 8'hBC, 3'd0, 25);
        do_reset("reset_wait_op");
        check_all("post_reset");

        // random activity
        for (int k = 0; k < 16; k++) begin
            r = $urandom_range(0, 5);
            case (r)
                0:       do_load("rnd_glitch_load", 8'($urandom), 3'($urandom), $urandom_range(1, 12));
                1:       do_clear("rnd_glitch_clear", 1'b0, $urandom_range(1, 12));
                2:       do_clear("rnd_clear", 1'b0, $urandom_range(20, 40));
                3:       do_clear("rnd_both", 1'b1, $urandom_range(20, 40));
                default: do_load("rnd_load", 8'($urandom), 3'($urandom), $urandom_range(20, 60));
            endcase
        end

        // button already held when reset releases gives one event
        @(negedge clk);
        sw_data = 8'h5A;
        btn_load = 1'b1;
        do_reset("reset_held");
        repeat (40) @(negedge clk);
        model_load(8'h5A, 3'd0);
        btn_load = 1'b0;
        repeat (25) @(negedge clk);
        check_all("held_through_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
